// File: rtl/input_acc_sched.sv
// Job sequencer for the input_acc FIFO bank: gates per-row writes from one source
// up to a programmed length, then issues diagonally skewed per-row dequeue strobes.
module input_acc_sched #(
  parameter int NUM_ROWS = 2,
  parameter int DEPTH    = 4,
  parameter int LEN_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_in,
  input  logic [LEN_W-1:0]    len_in,
  input  logic                src_nn_in,
  input  logic                abort_in,
  input  logic [NUM_ROWS-1:0] host_valid_in,
  input  logic [NUM_ROWS-1:0] nn_valid_in,
  output logic [NUM_ROWS-1:0] acc_valid_data_out,
  output logic [NUM_ROWS-1:0] acc_valid_data_nn_out,
  output logic [NUM_ROWS-1:0] acc_valid_in_out,
  output logic                busy_out,
  output logic                done_out
);

  localparam int T_W = $clog2(DEPTH + NUM_ROWS) + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q;
  logic                src_nn_q;
  logic [LEN_W-1:0]    wc_q [NUM_ROWS];
  logic [LEN_W-1:0]    wc_d [NUM_ROWS];
  logic [T_W-1:0]      t_q, t_d;
  logic [T_W-1:0]      len_t, t_last;
  logic [LEN_W-1:0]    len_clip;
  logic [NUM_ROWS-1:0] sel_valid, pass;
  logic                all_full, latch, clr;

  assign len_t    = T_W'(len_q);
  assign t_last   = len_t + T_W'(NUM_ROWS) - T_W'(2);
  assign len_clip = (len_in > DEPTH_L) ? DEPTH_L : len_in;

  // Only the latched source can reach the FIFOs, and only until a row is full.
  always_comb begin
    sel_valid = src_nn_q ? nn_valid_in : host_valid_in;
    all_full  = 1'b1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      pass[r] = sel_valid[r] && (state_q == S_LOAD) && (wc_q[r] < len_q);
      wc_d[r] = wc_q[r] + LEN_W'(pass[r]);
      if (wc_d[r] != len_q) all_full = 1'b0;
    end
    acc_valid_data_out    = src_nn_q ? '0 : pass;
    acc_valid_data_nn_out = src_nn_q ? pass : '0;
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    latch   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in && (len_in != '0)) begin
          latch   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_in) begin
          clr     = 1'b1;
          state_d = S_IDLE;
        end else if (all_full) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_in) begin
          clr     = 1'b1;
          state_d = S_IDLE;
        end else if (t_q == t_last) begin
          t_d     = '0;
          state_d = S_DONE;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      src_nn_q <= 1'b0;
      t_q      <= '0;
      for (int r = 0; r < NUM_ROWS; r++) wc_q[r] <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        len_q    <= len_clip;
        src_nn_q <= src_nn_in;
        t_q      <= '0;
        for (int r = 0; r < NUM_ROWS; r++) wc_q[r] <= '0;
      end else if (clr) begin
        t_q <= '0;
        for (int r = 0; r < NUM_ROWS; r++) wc_q[r] <= '0;
      end else begin
        t_q <= t_d;
        for (int r = 0; r < NUM_ROWS; r++) wc_q[r] <= wc_d[r];
      end
    end
  end

  // Row r dequeues while 0 <= t-r < L; the offset form avoids a constant compare.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_deq
    localparam logic [T_W-1:0] ROW = T_W'(r);
    logic [T_W:0] off;
    assign off = {1'b0, t_q} - {1'b0, ROW};
    assign acc_valid_in_out[r] = (state_q == S_DRAIN) && !off[T_W] &&
                                 (off[T_W-1:0] < len_t);
  end

  assign busy_out = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done_out = (state_q == S_DONE);

endmodule

// File: tb/tb_input_acc_sched.sv
// Directed bench for input_acc_sched (NUM_ROWS=2, DEPTH=4) with hand-computed
// per-cycle expectations for gating, skewed dequeue, abort and async reset.
module tb_input_acc_sched;

  logic       clk;
  logic       rst;
  logic       start_in;
  logic [2:0] len_in;
  logic       src_nn_in;
  logic       abort_in;
  logic [1:0] host_valid_in;
  logic [1:0] nn_valid_in;
  logic [1:0] acc_valid_data_out;
  logic [1:0] acc_valid_data_nn_out;
  logic [1:0] acc_valid_in_out;
  logic       busy_out;
  logic       done_out;

  int total = 0;
  int bad   = 0;

  input_acc_sched #(.NUM_ROWS(2), .DEPTH(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_in             (start_in),
    .len_in               (len_in),
    .src_nn_in            (src_nn_in),
    .abort_in             (abort_in),
    .host_valid_in        (host_valid_in),
    .nn_valid_in          (nn_valid_in),
    .acc_valid_data_out   (acc_valid_data_out),
    .acc_valid_data_nn_out(acc_valid_data_nn_out),
    .acc_valid_in_out     (acc_valid_in_out),
    .busy_out             (busy_out),
    .done_out             (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ex(input string tag, input logic [1:0] evin, input logic [1:0] ed,
                    input logic [1:0] enn, input logic eb, input logic edn);
    chk($sformatf("%s.vin", tag),  {6'd0, acc_valid_in_out},      {6'd0, evin});
    chk($sformatf("%s.dat", tag),  {6'd0, acc_valid_data_out},    {6'd0, ed});
    chk($sformatf("%s.nn", tag),   {6'd0, acc_valid_data_nn_out}, {6'd0, enn});
    chk($sformatf("%s.busy", tag), {7'd0, busy_out},              {7'd0, eb});
    chk($sformatf("%s.done", tag), {7'd0, done_out},              {7'd0, edn});
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance past the rising edge.
  task automatic cy(input string tag, input logic [1:0] h, input logic [1:0] n,
                    input logic st, input logic [2:0] ln, input logic src, input logic ab,
                    input logic [1:0] evin, input logic [1:0] ed, input logic [1:0] enn,
                    input logic eb, input logic edn);
    host_valid_in = h;
    nn_valid_in   = n;
    start_in      = st;
    len_in        = ln;
    src_nn_in     = src;
    abort_in      = ab;
    @(negedge clk);
    ex(tag, evin, ed, enn, eb, edn);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    start_in = 1'b0; len_in = '0; src_nn_in = 1'b0; abort_in = 1'b0;
    host_valid_in = '0; nn_valid_in = '0;
    #2;
    ex("rst", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Host load, L=3
    cy("h_start", 2'b00, 2'b00, 1, 3'd3, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("h_w1",    2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b11, 2'b00, 1, 0);
    cy("h_w2",    2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b11, 2'b00, 1, 0);
    cy("h_w3",    2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b11, 2'b00, 1, 0);
    cy("h_d0",    2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    cy("h_d1",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
    cy("h_d2",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
    cy("h_d3",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b10, 2'b00, 2'b00, 1, 0);
    cy("h_done",  2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    cy("h_idle",  2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);

    // Overflow on row 0, late second write on row 1, L=2
    cy("o_start", 2'b00, 2'b00, 1, 3'd2, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("o_w1",    2'b01, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0);
    cy("o_w2",    2'b01, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0);
    cy("o_w3",    2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 0);
    cy("o_w4",    2'b01, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    for (int i = 0; i < 4; i++)
      cy("o_wait", 2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    cy("o_r1",    2'b10, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 0);
    cy("o_d0",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    cy("o_d1",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
    cy("o_d2",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b10, 2'b00, 2'b00, 1, 0);
    cy("o_done",  2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);

    // NN source, start during DRAIN and DONE ignored, L=2
    cy("n_start", 2'b00, 2'b00, 1, 3'd2, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("n_w1",    2'b11, 2'b11, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b11, 1, 0);
    cy("n_w2",    2'b11, 2'b01, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0);
    cy("n_w3",    2'b01, 2'b11, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
    cy("n_d0",    2'b11, 2'b11, 1, 3'd1, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    cy("n_d1",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
    cy("n_d2",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b10, 2'b00, 2'b00, 1, 0);
    cy("n_done",  2'b00, 2'b00, 1, 3'd1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    cy("n_idle",  2'b11, 2'b11, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);

    // len 0 ignored; len 7 clips to 4
    cy("z_start", 2'b00, 2'b00, 1, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("z_idle",  2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("c_start", 2'b00, 2'b00, 1, 3'd7, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++)
      cy("c_w",   2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b11, 2'b00, 1, 0);
    cy("c_d0",    2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    cy("c_d1",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
    cy("c_d2",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
    cy("c_d3",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
    cy("c_d4",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b10, 2'b00, 2'b00, 1, 0);
    cy("c_done",  2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);

    // Abort at DRAIN t=1, then an L=1 job
    cy("a_start", 2'b00, 2'b00, 1, 3'd2, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("a_w1",    2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b11, 2'b00, 1, 0);
    cy("a_w2",    2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b11, 2'b00, 1, 0);
    cy("a_d0",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    cy("a_d1",    2'b00, 2'b00, 0, 3'd0, 0, 1, 2'b11, 2'b00, 2'b00, 1, 0);
    cy("a_idle0", 2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("a_idle1", 2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("b_start", 2'b00, 2'b00, 1, 3'd1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("b_w1",    2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b11, 2'b00, 1, 0);
    cy("b_d0",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    cy("b_d1",    2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b10, 2'b00, 2'b00, 1, 0);
    cy("b_done",  2'b00, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);

    // Asynchronous reset mid-LOAD
    cy("r_start", 2'b00, 2'b00, 1, 3'd3, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("r_w1",    2'b01, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0);
    host_valid_in = 2'b11;
    @(negedge clk);
    ex("r_pre", 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    ex("r_async", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    cy("r_hold0", 2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cy("r_hold1", 2'b11, 2'b00, 0, 3'd0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
